os_result_collector: RTL and testbench
======================================

Name: os_result_collector

Overview:
- Receive-side counterpart to the output-stationary matmul controller.
- Consumes the systolic array's bottom_out stream, qualified per column by output_col_valid.
- Outputs arrive bottom row first; the block un-reverses row order and assembles the full ROWS x COLS result matrix.
- Presents the matrix to downstream logic with a valid/ready handshake.

Parameters:
- ROWS, 4, systolic array rows (result matrix rows).
- COLS, 4, systolic array columns (result matrix columns).
- WORD_SIZE, 16, bits per element.
- TIMEOUT, 64, max cycles in COLLECT before forced abort; must be >= ROWS.

Ports:
- clk  in  1  clock, posedge sampling.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  start a new collection; honoured only in IDLE.
- bottom_out  in  COLS*WORD_SIZE  array bottom outputs; column c at [(c+1)*WORD_SIZE-1 -: WORD_SIZE].
- output_col_valid  in  COLS  per-column beat qualifier.
- result_matrix  out  ROWS*COLS*WORD_SIZE  element (r,c) at [(r*COLS+c+1)*WORD_SIZE-1 -: WORD_SIZE].
- result_valid  out  1  result_matrix complete and stable.
- result_ready  in  1  downstream accepts the result.
- busy  out  1  high in COLLECT or HOLD.
- timeout_err  out  1  sticky; set on abort, cleared on next accepted arm.

Behaviour:
- Reset (rst) values: state IDLE; result_matrix 0; result_valid 0; busy 0; timeout_err 0; all column counters 0; timer 0.
- Inputs are sampled on posedge clk. The upstream controller drives on negedge, so the data is stable by then.
- State IDLE:
  - arm=1 clears column counters, timer and timeout_err; go to COLLECT.
  - result_matrix keeps its last value.
  - output_col_valid beats in IDLE are ignored.
- State COLLECT:
  - Each column c has a counter cnt[c] of width clog2(ROWS)+1.
  - On a beat (output_col_valid[c]=1 and cnt[c] < ROWS): write bottom_out column c to element (ROWS-1-cnt[c], c), then cnt[c]++.
  - Beats with cnt[c] == ROWS are ignored; this covers surplus trailing beats.
  - Columns advance independently; partial valid masks are legal.
  - Timer increments every cycle.
  - When every cnt[c]==ROWS (including the cycle the final beat is written), go to HOLD next cycle; result_valid=1 from that cycle.
  - If the timer reaches TIMEOUT-1 while still incomplete: set timeout_err and go to HOLD. The unwritten elements keep their old values.
  - A completion beat and the timeout landing in the same cycle count as completion; timeout_err is not set.
- State HOLD:
  - result_valid=1; result_matrix frozen; bottom_out beats ignored.
  - result_valid && result_ready: go to IDLE next cycle; result_valid drops.
  - arm in HOLD is ignored.
- Latency: result_valid rises 1 cycle after the cycle that captures the last beat.
- busy = (state != IDLE).
- rst asserted mid-COLLECT or mid-HOLD returns everything to reset values in the next cycle; the partial matrix is discarded.

Optional Feature:
- Macro: OS_COLLECT_STATS_EN.
- With the macro defined:
  - Output port latency_cycles [15:0] is added, holding the COLLECT timer value captured on entry to HOLD. It is 0 at reset, saturates at 16'hFFFF, and is stable while result_valid=1.
  - Output port extra_beats [7:0] is added. It counts ignored column beats (cnt[c]==ROWS) summed across columns, in COLLECT and HOLD. It saturates, and clears on accepted arm.
- Without the macro: neither port nor its logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package os_collect_pkg holds:
  - state enum typedef {IDLE, COLLECT, HOLD};
  - column counter width localparam (clog2(ROWS)+1);
  - an element index function (r,c) -> bit offset.
- ROWS/COLS defaults come from header.vh macros.
- One natural sub-module: os_col_capture. It is instantiated per column and owns cnt[c], the reversed-row write into its column slice, and its done flag and extra-beat pulse.
- The top level holds the FSM, timer and handshake.

Test Plan (ROWS=COLS=3, WORD_SIZE=16):
- Normal collection:
  - Stimulus: arm, then 3 full-valid beats with bottom=[22,21,20], [12,11,10], [2,1,0] (col2..col0).
  - Required: result_valid one cycle after beat 3; element (r,c) = 10r+c.
  - Then hold result_ready=0 for 5 cycles: matrix stable and valid stays high. Assert ready: IDLE next cycle.
- Surplus beats:
  - Stimulus: 4 full-valid beats, the 4th with value 99.
  - Required: matrix identical to the normal case; with STATS_EN, extra_beats=3.
- Ragged columns:
  - Stimulus: valid masks 3'b001, 3'b011, 3'b111, 3'b110, 3'b100.
  - Required: completes after the 5th beat with correct row reversal in each column.
- Timeout:
  - Stimulus: arm, then only 2 full beats.
  - Required: at cycle TIMEOUT, timeout_err=1 and result_valid=1; row 0 holds its prior values.
  - A next arm clears timeout_err.
- Reset mid-COLLECT:
  - Stimulus: rst after 1 beat.
  - Required: next cycle result_matrix=0, busy=0, result_valid=0; a following clean run collects correctly.
- Arm and beats outside COLLECT:
  - Stimulus: arm pulses and valid beats during HOLD.
  - Required: no state change and matrix unchanged.

Source files
------------

// File: rtl/os_result_collector_pkg.sv
// os_collect_pkg: shared state type, size defaults and index helpers for os_result_collector.
// Optional statistics ports are enabled with OS_COLLECT_STATS_EN.
`ifndef OS_ROWS
`define OS_ROWS 4
`endif
`ifndef OS_COLS
`define OS_COLS 4
`endif
package os_collect_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;
  localparam int CNT_W = $clog2(`OS_ROWS) + 1;
  function automatic int cnt_width(int rows);
    return $clog2(rows) + 1;
  endfunction
  function automatic int elem_off(int r, int c, int cols, int w);
    return (r * cols + c) * w;
  endfunction
endpackage

// File: rtl/os_result_collector_if.sv
// os_result_collector_if: beat stream in, result matrix handshake out (stats signals under OS_COLLECT_STATS_EN).
interface os_result_collector_if #(
  parameter int ROWS = `OS_ROWS,
  parameter int COLS = `OS_COLS,
  parameter int WORD_SIZE = 16
);
  logic arm;
  logic [COLS*WORD_SIZE-1:0] bottom_out;
  logic [COLS-1:0] output_col_valid;
  logic [ROWS*COLS*WORD_SIZE-1:0] result_matrix;
  logic result_valid;
  logic result_ready;
  logic busy;
  logic timeout_err;
`ifdef OS_COLLECT_STATS_EN
  logic [15:0] latency_cycles;
  logic [7:0] extra_beats;
`endif
  modport slave (
    input arm, bottom_out, output_col_valid, result_ready,
    output result_matrix, result_valid, busy, timeout_err
`ifdef OS_COLLECT_STATS_EN
    , output latency_cycles, extra_beats
`endif
  );
  modport master (
    output arm, bottom_out, output_col_valid, result_ready,
    input result_matrix, result_valid, busy, timeout_err
`ifdef OS_COLLECT_STATS_EN
    , input latency_cycles, extra_beats
`endif
  );
endinterface

// File: rtl/os_result_collector_col_capture.sv
// os_col_capture: one result column; first beat lands in the bottom row, later beats climb upward.
import os_collect_pkg::*;
module os_col_capture #(
  parameter int ROWS = `OS_ROWS,
  parameter int WORD_SIZE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic v,
  input  logic [WORD_SIZE-1:0] din,
  output logic [ROWS*WORD_SIZE-1:0] col,
  output logic done
`ifdef OS_COLLECT_STATS_EN
  , output logic extra
`endif
);
  localparam int CW = cnt_width(ROWS);
  localparam logic [CW-1:0] FULL = CW'(ROWS);
  logic [CW-1:0] cnt;
  logic hit;
  assign hit = en & v & (cnt != FULL);
  // done also covers the cycle whose beat fills the column, so the FSM leaves without a bubble
  assign done = (cnt == FULL) | (hit & (cnt == FULL - 1'b1));
`ifdef OS_COLLECT_STATS_EN
  assign extra = v & (cnt == FULL);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      col <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (hit) begin
      col[(ROWS - 1 - int'(cnt)) * WORD_SIZE +: WORD_SIZE] <= din;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/os_result_collector.sv
// os_result_collector: reassembles the output-stationary array's bottom stream into a ROWS x COLS matrix.
// Define OS_COLLECT_STATS_EN for latency_cycles / extra_beats reporting.
import os_collect_pkg::*;
module os_result_collector #(
  parameter int ROWS = `OS_ROWS,
  parameter int COLS = `OS_COLS,
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  os_result_collector_if.slave bus
);
  state_e state;
  logic [15:0] timer;
  logic [COLS-1:0] done;
  logic clr, en, all_done, expire, terr;
`ifdef OS_COLLECT_STATS_EN
  logic [COLS-1:0] xp;
  logic [8:0] xsum;
  logic [15:0] lat;
  logic [7:0] xb;
`endif
  assign clr = (state == IDLE) & bus.arm;
  assign en = state == COLLECT;
  assign all_done = &done;
  assign expire = timer == 16'(TIMEOUT - 1);
  assign bus.result_valid = state == HOLD;
  assign bus.busy = state != IDLE;
  assign bus.timeout_err = terr;
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [ROWS*WORD_SIZE-1:0] col;
    os_col_capture #(.ROWS(ROWS), .WORD_SIZE(WORD_SIZE)) u_cap (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .en(en),
      .v(bus.output_col_valid[c]),
      .din(bus.bottom_out[c*WORD_SIZE +: WORD_SIZE]),
      .col(col),
      .done(done[c])
`ifdef OS_COLLECT_STATS_EN
      , .extra(xp[c])
`endif
    );
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign bus.result_matrix[elem_off(r, c, COLS, WORD_SIZE) +: WORD_SIZE] = col[r*WORD_SIZE +: WORD_SIZE];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      terr <= 1'b0;
    end else if (clr) begin
      state <= COLLECT;
      timer <= '0;
      terr <= 1'b0;
    end else if (en) begin
      timer <= timer + {15'd0, ~&timer};
      if (all_done | expire) state <= HOLD;
      if (!all_done & expire) terr <= 1'b1;
    end else if (state == HOLD && bus.result_ready) begin
      state <= IDLE;
    end
  end
`ifdef OS_COLLECT_STATS_EN
  assign xsum = {1'b0, xb} + 9'($countones(xp));
  assign bus.latency_cycles = lat;
  assign bus.extra_beats = xb;
  always_ff @(posedge clk) begin
    if (rst) begin
      lat <= '0;
      xb <= '0;
    end else begin
      if (clr) xb <= '0;
      else if (state != IDLE) xb <= xsum[8] ? 8'hFF : xsum[7:0];
      if (en & (all_done | expire)) lat <= timer + {15'd0, ~&timer};
    end
  end
`endif
endmodule

// File: tb/tb_os_result_collector.sv
// tb_os_result_collector: table vectors, directed corner sequences and random traffic against a matrix-level model.
module tb_os_result_collector;
  localparam int R = 3, C = 3, W = 16, TO = 16;
  localparam int MW = R * C * W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  os_result_collector_if #(.ROWS(R), .COLS(C), .WORD_SIZE(W)) bus();
  os_result_collector #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int nvec = 0, nerr = 0;
  int m_mode, m_t, m_extra, m_lat;
  int m_cnt[C];
  int m_mat[R][C];
  bit m_err;

  typedef struct {
    bit arm;
    bit [C-1:0] v;
    logic [C*W-1:0] b;
    bit rd;
    bit ev;
    bit eb;
  } vec_t;

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] pack_model();
    logic [MW-1:0] o;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) o[(r*C+c)*W +: W] = W'(m_mat[r][c]);
    return o;
  endfunction

  function automatic logic [MW-1:0] ramp(input int k);
    logic [MW-1:0] o;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) o[(r*C+c)*W +: W] = W'(k + 10*r + c);
    return o;
  endfunction

  function automatic logic [C*W-1:0] row_beat(input int k, input int row);
    logic [C*W-1:0] o;
    for (int c = 0; c < C; c++) o[c*W +: W] = W'(k + 10*row + c);
    return o;
  endfunction

  task automatic model_step(input bit a, input bit [C-1:0] v, input logic [C*W-1:0] b, input bit rd, input bit r);
    bit full;
    if (r) begin
      m_mode = 0; m_t = 0; m_err = 0; m_extra = 0; m_lat = 0;
      for (int c = 0; c < C; c++) m_cnt[c] = 0;
      for (int i = 0; i < R; i++) for (int c = 0; c < C; c++) m_mat[i][c] = 0;
      return;
    end
    if (m_mode == 0) begin
      if (a) begin
        m_mode = 1; m_t = 0; m_err = 0; m_extra = 0;
        for (int c = 0; c < C; c++) m_cnt[c] = 0;
      end
    end else if (m_mode == 1) begin
      full = 1;
      for (int c = 0; c < C; c++) begin
        if (v[c]) begin
          if (m_cnt[c] < R) begin
            m_mat[R-1-m_cnt[c]][c] = int'(b[c*W +: W]);
            m_cnt[c]++;
          end else m_extra++;
        end
        if (m_cnt[c] != R) full = 0;
      end
      if (full || m_t == TO - 1) begin
        m_mode = 2;
        if (!full) m_err = 1;
        m_lat = m_t + 1;
      end
      m_t++;
    end else begin
      for (int c = 0; c < C; c++) if (v[c] && m_cnt[c] == R) m_extra++;
      if (rd) m_mode = 0;
    end
    if (m_extra > 255) m_extra = 255;
  endtask

  task automatic check_all();
    chk("valid", MW'(bus.result_valid), MW'(m_mode == 2));
    chk("busy", MW'(bus.busy), MW'(m_mode != 0));
    chk("timeout_err", MW'(bus.timeout_err), MW'(m_err));
    chk("matrix", bus.result_matrix, pack_model());
`ifdef OS_COLLECT_STATS_EN
    chk("extra_beats", MW'(bus.extra_beats), MW'(m_extra));
    chk("latency", MW'(bus.latency_cycles), MW'(m_lat));
`endif
  endtask

  task automatic cyc(input bit a, input bit [C-1:0] v, input logic [C*W-1:0] b, input bit rd, input bit r);
    bus.arm = a; bus.output_col_valid = v; bus.bottom_out = b; bus.result_ready = rd; rst = r;
    @(posedge clk);
    model_step(a, v, b, rd, r);
    #1;
    check_all();
  endtask

  task automatic run_full(input int k);
    cyc(1, 0, '0, 0, 0);
    for (int j = 0; j < R; j++) cyc(0, '1, row_beat(k, R-1-j), 0, 0);
  endtask

  vec_t tbl[10];
  bit [C-1:0] masks[5];
  int jc[C];
  logic [C*W-1:0] b;
  logic [MW-1:0] exp_to;

  initial begin
    bus.arm = 0; bus.output_col_valid = '0; bus.bottom_out = '0; bus.result_ready = 0;
    cyc(0, 0, '0, 0, 1);
    cyc(0, 0, '0, 0, 1);
    chk("rst_matrix", bus.result_matrix, '0);
    chk("rst_valid", MW'(bus.result_valid), '0);
    chk("rst_busy", MW'(bus.busy), '0);
    chk("rst_err", MW'(bus.timeout_err), '0);

    // normal collection, then ready held low with arm/beats arriving during HOLD
    tbl[0] = '{1, 3'b000, '0, 0, 0, 1};
    tbl[1] = '{0, 3'b111, {16'd22, 16'd21, 16'd20}, 0, 0, 1};
    tbl[2] = '{0, 3'b111, {16'd12, 16'd11, 16'd10}, 0, 0, 1};
    tbl[3] = '{0, 3'b111, {16'd2, 16'd1, 16'd0}, 0, 1, 1};
    tbl[4] = '{1, 3'b111, 48'hdead_beef_cafe, 0, 1, 1};
    tbl[5] = '{1, 3'b000, '0, 0, 1, 1};
    tbl[6] = '{0, 3'b101, 48'h1234_5678_9abc, 0, 1, 1};
    tbl[7] = '{0, 3'b000, '0, 0, 1, 1};
    tbl[8] = '{0, 3'b000, '0, 0, 1, 1};
    tbl[9] = '{0, 3'b000, '0, 1, 0, 0};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].arm, tbl[i].v, tbl[i].b, tbl[i].rd, 0);
      chk($sformatf("tbl%0d_valid", i), MW'(bus.result_valid), MW'(tbl[i].ev));
      chk($sformatf("tbl%0d_busy", i), MW'(bus.busy), MW'(tbl[i].eb));
      if (i >= 3) chk($sformatf("tbl%0d_matrix", i), bus.result_matrix, ramp(0));
    end

    // ragged columns, values offset by 100
    masks = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100};
    for (int c = 0; c < C; c++) jc[c] = 0;
    cyc(1, 0, '0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      b = '0;
      for (int c = 0; c < C; c++)
        if (masks[i][c]) begin
          b[c*W +: W] = W'(100 + 10*(R-1-jc[c]) + c);
          jc[c]++;
        end
      cyc(0, masks[i], b, 0, 0);
      if (i == 3) chk("rag_not_early", MW'(bus.result_valid), '0);
    end
    chk("rag_valid", MW'(bus.result_valid), 1);
    chk("rag_matrix", bus.result_matrix, ramp(100));
    cyc(0, 0, '0, 1, 0);

    // surplus trailing beat
    run_full(0);
    cyc(0, '1, {16'd99, 16'd99, 16'd99}, 0, 0);
    chk("sur_matrix", bus.result_matrix, ramp(0));
    chk("sur_valid", MW'(bus.result_valid), 1);
`ifdef OS_COLLECT_STATS_EN
    chk("sur_extra", MW'(bus.extra_beats), 3);
`endif
    cyc(0, 0, '0, 1, 0);

    // timeout after two beats; row 0 keeps 0,1,2
    exp_to = ramp(200);
    for (int c = 0; c < C; c++) exp_to[c*W +: W] = W'(c);
    cyc(1, 0, '0, 0, 0);
    for (int i = 0; i < TO; i++) begin
      cyc(0, i < 2 ? 3'b111 : 3'b000, i < 2 ? row_beat(200, R-1-i) : '0, 0, 0);
      if (i == TO - 2) chk("to_early", MW'(bus.result_valid), '0);
    end
    chk("to_valid", MW'(bus.result_valid), 1);
    chk("to_err", MW'(bus.timeout_err), 1);
    chk("to_matrix", bus.result_matrix, exp_to);
    cyc(0, 0, '0, 1, 0);
    chk("to_err_sticky", MW'(bus.timeout_err), 1);
    cyc(1, 0, '0, 0, 0);
    chk("to_err_clear", MW'(bus.timeout_err), '0);

    // reset mid-collect, then a clean run
    cyc(0, '1, row_beat(300, R-1), 0, 0);
    cyc(0, 0, '0, 0, 1);
    chk("mrst_matrix", bus.result_matrix, '0);
    chk("mrst_busy", MW'(bus.busy), '0);
    chk("mrst_valid", MW'(bus.result_valid), '0);
    run_full(0);
    chk("post_rst_matrix", bus.result_matrix, ramp(0));
    chk("post_rst_valid", MW'(bus.result_valid), 1);
    cyc(0, 0, '0, 1, 0);

    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) == 0, C'($urandom), {$urandom, $urandom}, $urandom_range(0, 2) == 0,
          $urandom_range(0, 99) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
